// File: rtl/clk_mode_pkg.sv
// clk_mode_pkg: shared types and helpers for the clock-mode sequencer.
//   cms_state_e : sequencer FSM states
//   dly_width() : width of the shared delay counter, sized from the largest
//                 interval it has to time (load values are interval-1)
package clk_mode_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_IDLE,
        S_GATE,
        S_SWITCH,
        S_SETTLE,
        S_DONE
    } cms_state_e;

    function automatic int dly_width(input int g, input int s, input int t);
        int m;
        m = g;
        if (s > m) m = s;
        if (t > m) m = t;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

    // Counter width for the default interval set (2, 4, 16).
    localparam int DLY_W_DEF = dly_width(2, 4, 16);

endpackage

// File: rtl/cms_delay_cnt.sv
// cms_delay_cnt: loadable down-counter with a zero flag.
//   clk, rst_n : clock, async active-low reset
//   load       : load load_val (wins over dec)
//   dec        : decrement, saturating at zero
//   zero       : counter currently at zero
module cms_delay_cnt
    import clk_mode_pkg::*;
#(
    parameter int W = DLY_W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec && cnt != '0)
            cnt <= cnt - W'(1);
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/clk_mode_seq.sv
// clk_mode_seq: sequences a safe change of the latch/flop mode select.
// Waits for the datapath to go idle, gates its clock, flips SEL while the
// clock is stopped, lets it settle, re-enables the clock and acknowledges.
//   CLK, RST_N  : clock, async active-low reset
//   REQ         : level request, held until ACK
//   MODE_REQ    : requested SEL, sampled when REQ is accepted
//   DP_IDLE     : datapath quiescent
//   SEL         : mode select to clock switch / D_FF_LATCH
//   CLK_EN      : datapath clock enable (1 = running)
//   BUSY        : sequence in progress
//   ACK / ERR   : one-cycle completion pulse / abort flag with it
//   SWITCH_CNT  : completed SEL changes, wraps
module clk_mode_seq
    import clk_mode_pkg::*;
#(
    parameter int GATE_CYC     = 2,
    parameter int SETTLE_CYC   = 4,
    parameter int IDLE_TIMEOUT = 16,
    parameter bit SEL_RST      = 1'b1,
    parameter int CNT_W        = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             REQ,
    input  logic             MODE_REQ,
    input  logic             DP_IDLE,
    output logic             SEL,
    output logic             CLK_EN,
    output logic             BUSY,
    output logic             ACK,
    output logic             ERR,
    output logic [CNT_W-1:0] SWITCH_CNT
);

    localparam int DLY_W = dly_width(GATE_CYC, SETTLE_CYC, IDLE_TIMEOUT);

    cms_state_e       state;
    logic             target;
    logic             abort;
    logic             dly_load;
    logic             dly_dec;
    logic [DLY_W-1:0] dly_val;
    logic             dly_zero;

    // One counter times every interval; each state loads it on entry with
    // interval-1 so that "zero" marks the last cycle of the interval.
    always_comb begin
        dly_load = 1'b0;
        dly_dec  = 1'b0;
        dly_val  = '0;
        case (state)
            S_IDLE: begin
                dly_load = REQ && (MODE_REQ != SEL);
                dly_val  = DLY_W'(IDLE_TIMEOUT - 1);
            end
            S_WAIT_IDLE: begin
                dly_load = DP_IDLE;
                dly_dec  = !DP_IDLE;
                dly_val  = DLY_W'(GATE_CYC - 1);
            end
            S_SWITCH: begin
                dly_load = 1'b1;
                dly_val  = DLY_W'(SETTLE_CYC - 1);
            end
            S_GATE, S_SETTLE: dly_dec = 1'b1;
            default: ;
        endcase
    end

    cms_delay_cnt #(.W(DLY_W)) u_dly (
        .clk      (CLK),
        .rst_n    (RST_N),
        .load     (dly_load),
        .dec      (dly_dec),
        .load_val (dly_val),
        .zero     (dly_zero)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= S_IDLE;
            target     <= SEL_RST;
            abort      <= 1'b0;
            SEL        <= SEL_RST;
            CLK_EN     <= 1'b1;
            BUSY       <= 1'b0;
            ACK        <= 1'b0;
            ERR        <= 1'b0;
            SWITCH_CNT <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    ACK  <= 1'b0;
                    ERR  <= 1'b0;
                    BUSY <= REQ;
                    if (REQ) begin
                        abort  <= 1'b0;
                        target <= MODE_REQ;
                        // Already in the requested mode: just acknowledge.
                        state  <= (MODE_REQ == SEL) ? S_DONE : S_WAIT_IDLE;
                    end
                end
                S_WAIT_IDLE: begin
                    if (DP_IDLE) begin
                        CLK_EN <= 1'b0;
                        state  <= S_GATE;
                    end else if (dly_zero) begin
                        abort <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_GATE: begin
                    // SEL is registered on the way into SWITCH so it moves
                    // exactly GATE_CYC cycles after CLK_EN fell; SWITCH is
                    // then the first cycle with the new mode, clock stopped.
                    if (dly_zero) begin
                        SEL        <= target;
                        SWITCH_CNT <= SWITCH_CNT + CNT_W'(1);
                        state      <= S_SWITCH;
                    end
                end
                S_SWITCH: state <= S_SETTLE;
                S_SETTLE: begin
                    if (dly_zero) begin
                        CLK_EN <= 1'b1;
                        state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    // BUSY stays high through the ACK cycle, drops in IDLE.
                    ACK   <= 1'b1;
                    ERR   <= abort;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_clk_mode_seq.sv
// tb_clk_mode_seq: scoreboard bench for clk_mode_seq. Each request pushes
// its expected outcome; a negedge monitor measures the CLK_EN-low window,
// SEL timing and ACK latency, and compares on every ACK.
module tb_clk_mode_seq;

    localparam int G  = 2;
    localparam int S  = 4;
    localparam int T  = 16;
    localparam int CW = 8;

    logic          CLK, RST_N, REQ, MODE_REQ, DP_IDLE;
    logic          SEL, CLK_EN, BUSY, ACK, ERR;
    logic [CW-1:0] SWITCH_CNT;

    clk_mode_seq #(
        .GATE_CYC(G), .SETTLE_CYC(S), .IDLE_TIMEOUT(T),
        .SEL_RST(1'b1), .CNT_W(CW)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .MODE_REQ(MODE_REQ),
        .DP_IDLE(DP_IDLE), .SEL(SEL), .CLK_EN(CLK_EN), .BUSY(BUSY),
        .ACK(ACK), .ERR(ERR), .SWITCH_CNT(SWITCH_CNT)
    );

    typedef struct {
        int            acc;
        int            lat;
        logic          err;
        logic          sel;
        logic [CW-1:0] cnt;
        int            low;
        int            off;
    } exp_t;

    exp_t          q[$];
    int            nchk, npass, cyc;
    int            fall_cyc, low_len, sel_off, ack_cnt;
    logic          pclk_en, psel;
    logic          m_sel;
    logic [CW-1:0] m_cnt;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got === exp) npass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Monitor: measures gating window and SEL move, scores each ACK.
    initial begin
        pclk_en  = 1'b1;
        psel     = 1'b1;
        fall_cyc = 0;
        low_len  = 0;
        sel_off  = -1;
        ack_cnt  = 0;
    end

    always @(negedge CLK) begin
        exp_t e;
        if (!RST_N) begin
            low_len = 0;
            sel_off = -1;
        end else begin
            if (pclk_en && !CLK_EN) fall_cyc = cyc;
            if (!pclk_en && CLK_EN) low_len = cyc - fall_cyc;
            if (SEL !== psel) begin
                if (!CLK_EN) sel_off = cyc - fall_cyc;
                else chk("sel_gated", CLK_EN, 0);
            end
            if (ACK) begin
                ack_cnt++;
                if (q.size() == 0) begin
                    chk("ack_unexp", ACK, 0);
                end else begin
                    e = q.pop_front();
                    chk("ack_lat", cyc - e.acc, e.lat);
                    chk("err", ERR, e.err);
                    chk("sel", SEL, e.sel);
                    chk("cnt", SWITCH_CNT, e.cnt);
                    chk("en_low", low_len, e.low);
                    chk("sel_off", sel_off, e.off);
                    chk("busy_ack", BUSY, 1);
                    chk("clk_en_ack", CLK_EN, 1);
                end
                low_len = 0;
                sel_off = -1;
            end else if (ERR) begin
                chk("err_noack", ERR, 0);
            end
        end
        pclk_en = CLK_EN;
        psel    = SEL;
    end

    // idle_dly: 0 = DP_IDLE already high, n>0 = raised at the n-th negedge
    // after driving REQ, <0 = never. req_drop: negedge at which REQ falls.
    task automatic do_req(input logic mode, input int idle_dly, input int req_drop);
        exp_t e;
        bit   got;
        e.acc = cyc + 1;
        e.err = 1'b0;
        e.low = 0;
        e.off = -1;
        if (mode == m_sel) begin
            e.lat = 1;
        end else if (idle_dly < 0) begin
            e.lat = T + 1;
            e.err = 1'b1;
        end else begin
            e.lat = 1 + G + 1 + S + 1 + ((idle_dly > 0) ? idle_dly - 1 : 0);
            e.low = G + 1 + S;
            e.off = G;
            m_sel = mode;
            m_cnt = m_cnt + 1'b1;
        end
        e.sel = m_sel;
        e.cnt = m_cnt;
        q.push_back(e);
        DP_IDLE  = (idle_dly == 0);
        MODE_REQ = mode;
        REQ      = 1'b1;
        got      = 1'b0;
        for (int n = 1; n <= 60 && !got; n++) begin
            @(negedge CLK);
            if (n == idle_dly) DP_IDLE = 1'b1;
            if (n == req_drop) REQ = 1'b0;
            if (ACK) got = 1'b1;
        end
        if (!got) chk("ack_seen", ACK, 1);
        REQ     = 1'b0;
        DP_IDLE = 1'b1;
        @(negedge CLK);
        chk("ack_pulse", ACK, 0);
        chk("busy_clr", BUSY, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int acks0;
        bit seen;
        RST_N    = 1'b0;
        REQ      = 1'b0;
        MODE_REQ = 1'b0;
        DP_IDLE  = 1'b1;
        m_sel    = 1'b1;
        m_cnt    = '0;

        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            chk("rst_sel", SEL, 1);
            chk("rst_en", CLK_EN, 1);
            chk("rst_busy", BUSY, 0);
            chk("rst_cnt", SWITCH_CNT, 0);
        end
        RST_N = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("idle_sel", SEL, 1);
            chk("idle_en", CLK_EN, 1);
            chk("idle_busy", BUSY, 0);
            chk("idle_ack", ACK, 0);
        end

        do_req(1'b0, 0, -1);   // normal switch 1 -> 0
        do_req(1'b1, 0, -1);   // back to 1
        do_req(1'b1, 0, -1);   // no-op with SEL=1
        do_req(1'b0, -1, -1);  // DP_IDLE never rises: timeout abort
        do_req(1'b0, 5, 9);    // late DP_IDLE, REQ drops during SETTLE
        do_req(1'b0, 0, -1);   // no-op with SEL=0
        do_req(1'b1, 0, -1);   // back to 1 for the reset case

        // Reset in SETTLE after SEL has moved to 0.
        acks0    = ack_cnt;
        MODE_REQ = 1'b0;
        REQ      = 1'b1;
        seen     = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge CLK);
            if (SEL == 1'b0) seen = 1'b1;
        end
        chk("rst_mid_sel0", SEL, 0);
        @(negedge CLK);
        RST_N = 1'b0;
        #1;
        chk("rst_mid_sel", SEL, 1);
        chk("rst_mid_en", CLK_EN, 1);
        chk("rst_mid_busy", BUSY, 0);
        chk("rst_mid_ack", ACK, 0);
        chk("rst_mid_cnt", SWITCH_CNT, 0);
        REQ = 1'b0;
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        m_sel = 1'b1;
        m_cnt = '0;
        repeat (20) @(negedge CLK);
        chk("rst_mid_noack", ack_cnt, acks0);

        // 256 toggles wrap the switch counter back to 0.
        for (int i = 0; i < 256; i++) do_req(~m_sel, 0, -1);
        chk("cnt_wrap", SWITCH_CNT, 0);
        chk("q_empty", q.size(), 0);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
